// File: rtl/lane_pipe_regs.sv
// N-lane EX->MEM->WB pipeline registers with in-MEM branch resolution,
// single-shot frontend redirect, wrong-path squash and per-lane exception kill.
module lane_pipe_regs #(
    parameter  int LANES   = 2,
    parameter  int XLEN    = 32,
    parameter  int RADDR_W = 5,
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     stall,
    input  logic                     flush_csr,
    input  logic [LANES-1:0]         ex_valid,
    input  logic [LANES*XLEN-1:0]    ex_pc,
    input  logic [LANES*XLEN-1:0]    ex_result,
    input  logic [LANES-1:0]         ex_rf_we,
    input  logic [LANES*RADDR_W-1:0] ex_waddr,
    input  logic [LANES*XLEN-1:0]    ex_pred_pc,
    input  logic [LANES-1:0]         ex_br_taken,
    input  logic [LANES*XLEN-1:0]    ex_br_target,
    input  logic [LANES-1:0]         mem_exc,
    input  logic [LANES*XLEN-1:0]    mem_wdata,
    output logic [LANES-1:0]         mem_valid,
    output logic [LANES*XLEN-1:0]    mem_pc,
    output logic [LANES*XLEN-1:0]    mem_result,
    output logic [LANES-1:0]         mem_rf_we,
    output logic [LANES*RADDR_W-1:0] mem_waddr,
    output logic                     redirect,
    output logic [XLEN-1:0]          redirect_pc,
    output logic [LANE_W-1:0]        redirect_lane,
    output logic [LANES-1:0]         wb_valid,
    output logic [LANES*XLEN-1:0]    wb_pc,
    output logic [LANES-1:0]         wb_rf_we,
    output logic [LANES*RADDR_W-1:0] wb_waddr,
    output logic [LANES*XLEN-1:0]    wb_wdata
);

    logic [LANES-1:0]         r_m_valid;
    logic [LANES-1:0]         r_m_we;
    logic [LANES-1:0]         r_m_br_taken;
    logic [LANES*XLEN-1:0]    r_m_pc;
    logic [LANES*XLEN-1:0]    r_m_result;
    logic [LANES*XLEN-1:0]    r_m_pred_pc;
    logic [LANES*XLEN-1:0]    r_m_br_target;
    logic [LANES*RADDR_W-1:0] r_m_waddr;
    logic                     r_fired;

    logic [LANES-1:0]         r_w_valid;
    logic [LANES-1:0]         r_w_we;
    logic [LANES*XLEN-1:0]    r_w_pc;
    logic [LANES*XLEN-1:0]    r_w_wdata;
    logic [LANES*RADDR_W-1:0] r_w_waddr;

    logic                     w_advance;
    logic                     w_any_mp;
    logic [LANE_W-1:0]        w_k;
    logic [XLEN-1:0]          w_k_pc;
    logic [XLEN-1:0]          w_correct;
    logic                     w_exc_pre;
    logic                     w_exc_wb;
    logic [LANES-1:0]         w_kill;
    logic [LANES-1:0]         w_mem_valid;
    logic [LANES-1:0]         w_wb_valid_nxt;
    logic                     w_redirect;

    assign w_advance = ~stall;

    // Single walk oldest->youngest: the first unexcepted mispredict wins,
    // everything younger than it is killed, and WB drops from the first exception on.
    always_comb begin
        w_any_mp       = 1'b0;
        w_k            = '0;
        w_k_pc         = '0;
        w_correct      = '0;
        w_exc_pre      = 1'b0;
        w_exc_wb       = 1'b0;
        w_kill         = '0;
        w_mem_valid    = '0;
        w_wb_valid_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_correct = r_m_br_taken[i] ? r_m_br_target[i*XLEN +: XLEN]
                                        : r_m_pc[i*XLEN +: XLEN] + XLEN'(4);
            w_exc_pre = w_exc_pre | mem_exc[i];
            w_kill[i] = w_any_mp;
            if (!w_any_mp && r_m_valid[i] && !w_exc_pre
                && (r_m_pred_pc[i*XLEN +: XLEN] != w_correct)) begin
                w_any_mp = 1'b1;
                w_k      = LANE_W'(i);
                w_k_pc   = w_correct;
            end
            w_mem_valid[i]    = r_m_valid[i] & ~w_kill[i];
            w_exc_wb          = w_exc_wb | (mem_exc[i] & r_m_valid[i]);
            w_wb_valid_nxt[i] = w_mem_valid[i] & ~w_exc_wb;
        end
    end

    assign w_redirect    = w_any_mp & ~r_fired & ~flush_csr;
    assign redirect      = w_redirect;
    assign redirect_pc   = w_redirect ? w_k_pc : '0;
    assign redirect_lane = w_redirect ? w_k : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_m_valid     <= '0;
            r_m_we        <= '0;
            r_m_br_taken  <= '0;
            r_m_pc        <= '0;
            r_m_result    <= '0;
            r_m_pred_pc   <= '0;
            r_m_br_target <= '0;
            r_m_waddr     <= '0;
            r_fired       <= 1'b0;
            r_w_valid     <= '0;
            r_w_we        <= '0;
            r_w_pc        <= '0;
            r_w_wdata     <= '0;
            r_w_waddr     <= '0;
        end else begin
            // Fired only survives a stall so a long stall cannot re-issue the redirect.
            if (flush_csr || w_advance) begin
                r_fired <= 1'b0;
            end else if (w_redirect) begin
                r_fired <= 1'b1;
            end

            if (w_advance) begin
                r_m_br_taken  <= ex_br_taken;
                r_m_pc        <= ex_pc;
                r_m_result    <= ex_result;
                r_m_pred_pc   <= ex_pred_pc;
                r_m_br_target <= ex_br_target;
                r_m_waddr     <= ex_waddr;
                r_w_pc        <= r_m_pc;
                r_w_waddr     <= r_m_waddr;
                r_w_wdata     <= mem_wdata;
            end

            if (flush_csr) begin
                r_m_valid <= '0;
                r_m_we    <= '0;
                r_w_valid <= '0;
                r_w_we    <= '0;
            end else if (w_advance) begin
                r_m_valid <= w_any_mp ? '0 : ex_valid;
                r_m_we    <= w_any_mp ? '0 : ex_rf_we;
                r_w_valid <= w_wb_valid_nxt;
                r_w_we    <= w_wb_valid_nxt & r_m_we;
            end
        end
    end

    assign mem_valid  = w_mem_valid;
    assign mem_rf_we  = w_mem_valid & r_m_we;
    assign mem_pc     = r_m_pc;
    assign mem_result = r_m_result;
    assign mem_waddr  = r_m_waddr;

    assign wb_valid   = r_w_valid;
    assign wb_rf_we   = r_w_we;
    assign wb_pc      = r_w_pc;
    assign wb_waddr   = r_w_waddr;
    assign wb_wdata   = r_w_wdata;

endmodule

// File: tb/tb_lane_pipe_regs.sv
// Scoreboard bench for lane_pipe_regs: a per-lane bundle model predicts each
// cycle's outputs into a queue, a negedge monitor pops and compares.
module tb_lane_pipe_regs;
    localparam int L  = 2;
    localparam int X  = 32;
    localparam int R  = 5;
    localparam int LW = 1;

    logic           clk;
    logic           rstn;
    logic           stall;
    logic           flush_csr;
    logic [L-1:0]   ex_valid;
    logic [L*X-1:0] ex_pc;
    logic [L*X-1:0] ex_result;
    logic [L-1:0]   ex_rf_we;
    logic [L*R-1:0] ex_waddr;
    logic [L*X-1:0] ex_pred_pc;
    logic [L-1:0]   ex_br_taken;
    logic [L*X-1:0] ex_br_target;
    logic [L-1:0]   mem_exc;
    logic [L*X-1:0] mem_wdata;
    logic [L-1:0]   mem_valid;
    logic [L*X-1:0] mem_pc;
    logic [L*X-1:0] mem_result;
    logic [L-1:0]   mem_rf_we;
    logic [L*R-1:0] mem_waddr;
    logic           redirect;
    logic [X-1:0]   redirect_pc;
    logic [LW-1:0]  redirect_lane;
    logic [L-1:0]   wb_valid;
    logic [L*X-1:0] wb_pc;
    logic [L-1:0]   wb_rf_we;
    logic [L*R-1:0] wb_waddr;
    logic [L*X-1:0] wb_wdata;

    lane_pipe_regs #(.LANES(L), .XLEN(X), .RADDR_W(R)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush_csr(flush_csr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_result(ex_result),
        .ex_rf_we(ex_rf_we), .ex_waddr(ex_waddr), .ex_pred_pc(ex_pred_pc),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .mem_exc(mem_exc), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_result(mem_result),
        .mem_rf_we(mem_rf_we), .mem_waddr(mem_waddr),
        .redirect(redirect), .redirect_pc(redirect_pc), .redirect_lane(redirect_lane),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        we;
        logic        tk;
        logic [X-1:0] pc;
        logic [X-1:0] res;
        logic [X-1:0] pred;
        logic [X-1:0] tgt;
        logic [R-1:0] wa;
    } lane_t;

    typedef struct {
        logic [L-1:0]   mv, mwe, wv, wwe, mmask, wmask;
        logic           rd;
        logic [X-1:0]   rpc;
        logic [LW-1:0]  rlane;
        logic [L*X-1:0] mpc, mres, wpc, wwd;
        logic [L*R-1:0] mwa, wwa;
    } exp_t;

    lane_t mem_st[L];
    lane_t wb_st[L];
    bit    fired;
    bit    fresh;
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Predict outputs of the current cycle, then advance the model past the next edge.
    task automatic step();
        exp_t         e;
        bit           any;
        bit           excp;
        int           k;
        int           first_exc;
        logic [X-1:0] corr;
        logic [X-1:0] kpc;
        any = 0; excp = 0; k = 0; kpc = '0; first_exc = L;
        e = '{default: '0};
        for (int i = 0; i < L; i++) begin
            excp = excp | mem_exc[i];
            corr = mem_st[i].tk ? mem_st[i].tgt : mem_st[i].pc + 32'd4;
            if (!any && mem_st[i].v && !excp && mem_st[i].pred != corr) begin
                any = 1; k = i; kpc = corr;
            end
        end
        for (int i = 0; i < L; i++)
            if (first_exc == L && mem_exc[i] && mem_st[i].v) first_exc = i;
        for (int i = 0; i < L; i++) begin
            e.mv[i]            = mem_st[i].v && !(any && i > k);
            e.mwe[i]           = e.mv[i] && mem_st[i].we;
            e.mpc[i*X +: X]    = mem_st[i].pc;
            e.mres[i*X +: X]   = mem_st[i].res;
            e.mwa[i*R +: R]    = mem_st[i].wa;
            e.mmask[i]         = fresh || e.mv[i];
            e.wv[i]            = wb_st[i].v;
            e.wwe[i]           = wb_st[i].we;
            e.wpc[i*X +: X]    = wb_st[i].pc;
            e.wwd[i*X +: X]    = wb_st[i].res;
            e.wwa[i*R +: R]    = wb_st[i].wa;
            e.wmask[i]         = fresh || wb_st[i].v;
        end
        e.rd    = any && !fired && !flush_csr;
        e.rpc   = e.rd ? kpc : '0;
        e.rlane = e.rd ? LW'(k) : '0;
        exp_q.push_back(e);

        if (!rstn) begin
            for (int i = 0; i < L; i++) begin
                mem_st[i] = '{default: '0};
                wb_st[i]  = '{default: '0};
            end
            fired = 0;
            fresh = 1;
        end else begin
            if (flush_csr || !stall) fired = 0;
            else if (e.rd) fired = 1;
            if (!stall) begin
                for (int i = 0; i < L; i++) begin
                    wb_st[i].v   = e.mv[i] && (i < first_exc);
                    wb_st[i].we  = wb_st[i].v && mem_st[i].we;
                    wb_st[i].pc  = mem_st[i].pc;
                    wb_st[i].wa  = mem_st[i].wa;
                    wb_st[i].res = mem_wdata[i*X +: X];
                    mem_st[i].v    = any ? 1'b0 : ex_valid[i];
                    mem_st[i].we   = any ? 1'b0 : ex_rf_we[i];
                    mem_st[i].tk   = ex_br_taken[i];
                    mem_st[i].pc   = ex_pc[i*X +: X];
                    mem_st[i].res  = ex_result[i*X +: X];
                    mem_st[i].pred = ex_pred_pc[i*X +: X];
                    mem_st[i].tgt  = ex_br_target[i*X +: X];
                    mem_st[i].wa   = ex_waddr[i*R +: R];
                end
                fresh = 0;
            end
            if (flush_csr) begin
                for (int i = 0; i < L; i++) begin
                    mem_st[i].v = 0; mem_st[i].we = 0;
                    wb_st[i].v  = 0; wb_st[i].we  = 0;
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rstn = 1; stall = 0; flush_csr = 0;
        ex_valid = '0; ex_rf_we = '0; ex_br_taken = '0; mem_exc = '0;
        ex_pc = '0; ex_result = '0; ex_waddr = '0; ex_pred_pc = '0;
        ex_br_target = '0; mem_wdata = '0;
    endtask

    task automatic set_lane(input int i, input logic [X-1:0] pc, input logic [X-1:0] pred,
                            input logic tk, input logic [X-1:0] tgt,
                            input logic we, input logic [R-1:0] wa);
        ex_valid[i]            = 1'b1;
        ex_pc[i*X +: X]        = pc;
        ex_pred_pc[i*X +: X]   = pred;
        ex_br_taken[i]         = tk;
        ex_br_target[i*X +: X] = tgt;
        ex_rf_we[i]            = we;
        ex_waddr[i*R +: R]     = wa;
        ex_result[i*X +: X]    = pc ^ 32'h5A5A_0000;
    endtask

    task automatic mispredict_bundle();
        set_lane(0, 32'h2000, 32'h2004, 1'b1, 32'h3000, 1'b1, 5'd6);
        set_lane(1, 32'h2004, 32'h2008, 1'b0, 32'h0,    1'b1, 5'd7);
    endtask

    task automatic wrong_path_bundle();
        set_lane(0, 32'h5000, 32'h5004, 1'b0, 32'h0, 1'b1, 5'd8);
        set_lane(1, 32'h5004, 32'h5008, 1'b0, 32'h0, 1'b1, 5'd9);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("mem_valid",     mem_valid,     mon_e.mv);
                chk("mem_rf_we",     mem_rf_we,     mon_e.mwe);
                chk("redirect",      redirect,      mon_e.rd);
                chk("redirect_pc",   redirect_pc,   mon_e.rpc);
                chk("redirect_lane", redirect_lane, mon_e.rlane);
                chk("wb_valid",      wb_valid,      mon_e.wv);
                chk("wb_rf_we",      wb_rf_we,      mon_e.wwe);
                for (int i = 0; i < L; i++) begin
                    if (mon_e.mmask[i]) begin
                        chk("mem_pc",     mem_pc[i*X +: X],     mon_e.mpc[i*X +: X]);
                        chk("mem_result", mem_result[i*X +: X], mon_e.mres[i*X +: X]);
                        chk("mem_waddr",  mem_waddr[i*R +: R],  mon_e.mwa[i*R +: R]);
                    end
                    if (mon_e.wmask[i]) begin
                        chk("wb_pc",    wb_pc[i*X +: X],    mon_e.wpc[i*X +: X]);
                        chk("wb_wdata", wb_wdata[i*X +: X], mon_e.wwd[i*X +: X]);
                        chk("wb_waddr", wb_waddr[i*R +: R], mon_e.wwa[i*R +: R]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < L; i++) begin
            mem_st[i] = '{default: '0};
            wb_st[i]  = '{default: '0};
        end
        fired = 0;
        fresh = 1;
        idle();
        rstn = 0;
        repeat (3) @(posedge clk);

        go(); idle(); step();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wdata", wb_wdata, 0);

        // Plain bundle, no mispredict
        go(); idle();
        set_lane(0, 32'h1000, 32'h1004, 1'b0, 32'h0, 1'b1, 5'd3);
        set_lane(1, 32'h1004, 32'h1008, 1'b0, 32'h0, 1'b1, 5'd4);
        step();
        go(); idle(); mem_wdata = {32'hBB, 32'hAA}; step();
        chk("t1_no_redirect", redirect, 0);
        chk("t1_mem_we", mem_rf_we, 2'b11);
        go(); idle(); step();
        chk("t1_wb_we", wb_rf_we, 2'b11);
        chk("t1_wb_waddr", wb_waddr, {5'd4, 5'd3});
        chk("t1_wb_wdata0", wb_wdata[31:0], 32'hAA);

        // Lane0 mispredict, no stall
        go(); idle(); mispredict_bundle(); step();
        go(); idle(); wrong_path_bundle(); step();
        chk("t2_redirect", redirect, 1);
        chk("t2_redirect_pc", redirect_pc, 32'h3000);
        chk("t2_redirect_lane", redirect_lane, 0);
        chk("t2_mem_we", mem_rf_we, 2'b01);
        go(); idle(); step();
        chk("t2_mem_valid", mem_valid, 2'b00);
        chk("t2_wb_valid", wb_valid, 2'b01);
        go(); idle(); step();

        // Same mispredict held by a 4-cycle stall
        go(); idle(); mispredict_bundle(); step();
        go(); idle(); wrong_path_bundle(); stall = 1; step();
        chk("t3_redirect_first", redirect, 1);
        for (int c = 0; c < 3; c++) begin
            go(); idle(); wrong_path_bundle(); stall = 1; step();
            chk("t3_redirect_held", redirect, 0);
            chk("t3_mem_held", mem_valid, 2'b01);
        end
        go(); idle(); wrong_path_bundle(); step();
        chk("t3_redirect_release", redirect, 0);
        go(); idle(); step();
        chk("t3_mem_bubble", mem_valid, 2'b00);
        chk("t3_wb_valid", wb_valid, 2'b01);
        go(); idle(); step();

        // Both lanes mispredict: oldest wins
        go(); idle();
        set_lane(0, 32'h2000, 32'h2004, 1'b1, 32'h3000, 1'b1, 5'd1);
        set_lane(1, 32'h2004, 32'h2008, 1'b1, 32'h4000, 1'b1, 5'd2);
        step();
        go(); idle(); step();
        chk("t4_redirect", redirect, 1);
        chk("t4_redirect_lane", redirect_lane, 0);
        chk("t4_redirect_pc", redirect_pc, 32'h3000);
        go(); idle(); step();

        // Exception on lane0 suppresses lane1 redirect
        go(); idle();
        set_lane(0, 32'h2000, 32'h2004, 1'b0, 32'h0,    1'b1, 5'd1);
        set_lane(1, 32'h2004, 32'h2008, 1'b1, 32'h4000, 1'b1, 5'd2);
        step();
        go(); idle(); mem_exc = 2'b01; step();
        chk("t5_no_redirect", redirect, 0);
        chk("t5_mem_valid", mem_valid, 2'b11);
        go(); idle(); step();
        chk("t5_wb_valid", wb_valid, 2'b00);
        chk("t5_wb_we", wb_rf_we, 2'b00);

        // Flush during stall with a mispredict pending
        go(); idle(); mispredict_bundle(); step();
        go(); idle(); stall = 1; flush_csr = 1; step();
        chk("t6_flush_no_redirect", redirect, 0);
        go(); idle(); step();
        chk("t6_mem_valid", mem_valid, 2'b00);
        chk("t6_wb_valid", wb_valid, 2'b00);

        // PC wrap
        go(); idle();
        set_lane(0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b1, 5'd1);
        set_lane(1, 32'h0,         32'h4, 1'b0, 32'h0, 1'b1, 5'd2);
        step();
        go(); idle(); step();
        chk("t7_wrap_no_redirect", redirect, 0);
        go(); idle();
        set_lane(0, 32'hFFFF_FFFC, 32'h4, 1'b0, 32'h0, 1'b1, 5'd1);
        step();
        go(); idle(); step();
        chk("t7_wrap_redirect", redirect, 1);
        chk("t7_wrap_pc", redirect_pc, 32'h0);
        go(); idle(); step();

        // Reset mid-stream
        go(); idle(); wrong_path_bundle(); step();
        go(); idle(); wrong_path_bundle(); mem_wdata = {32'h11, 32'h22}; step();
        go(); idle(); rstn = 0; step();
        go(); idle(); step();
        chk("t8_mem_valid", mem_valid, 0);
        chk("t8_wb_valid", wb_valid, 0);
        chk("t8_mem_pc", mem_pc, 0);
        chk("t8_wb_pc", wb_pc, 0);
        chk("t8_redirect", redirect, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            go(); idle();
            rstn      = ($urandom_range(0, 199) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            flush_csr = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < L; i++) begin
                logic [X-1:0] pc, tgt, pred;
                logic         tk;
                pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
                tk   = $urandom_range(0, 1) == 1;
                tgt  = $urandom() & 32'hFFFF_FFFC;
                pred = tk ? tgt : pc + 32'd4;
                if ($urandom_range(0, 3) == 0) pred = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) != 0)
                    set_lane(i, pc, pred, tk, tgt, $urandom_range(0, 1) == 1, R'($urandom()));
                mem_exc[i]          = ($urandom_range(0, 9) == 0);
                mem_wdata[i*X +: X] = $urandom();
            end
            step();
        end

        go(); idle(); go();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
